// File: rtl/serial_bus_pkg.sv
// Shared definitions for the serial system bus: default field widths,
// the responder/serialiser state encoding and the header length helper.
package serial_bus_pkg;

    localparam int ADDR_LEN_DEF  = 12;
    localparam int DATA_LEN_DEF  = 8;
    localparam int BURST_LEN_DEF = 12;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HEADER    = 3'd1,
        WR_DATA   = 3'd2,
        WR_COMMIT = 3'd3,
        RD_FETCH  = 3'd4,
        RD_SEND   = 3'd5
    } bus_state_e;

    // Address and burst count travel side by side, so the header lasts as
    // long as the wider of the two fields.
    function automatic int hdr_len(input int addr_len, input int burst_len);
        return (addr_len > burst_len) ? addr_len : burst_len;
    endfunction

endpackage

// File: rtl/slave_bram.sv
// Single-port byte memory behind the slave responder: registered write,
// synchronous (read-first) read, shaped so synthesis maps it to block RAM.
module slave_bram
    import serial_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_LEN_DEF,
    parameter int DATA_W = DATA_LEN_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Write on enable; the read port samples every cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/serial_slave_responder.sv
// Slave-side responder: deserialises address/burst/write data from the
// master, commits write beats to local memory and serialises read beats back.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for a new transaction; first header bit starts one
// HEADER    | shifting address and burst count in parallel, LSB first
// WR_DATA   | shifting one write beat, LSB first
// WR_COMMIT | one cycle: beat written to memory, address/remaining stepped
// RD_FETCH  | one cycle: memory data for the current address is arriving
// RD_SEND   | serialising the fetched beat under master_ready
module serial_slave_responder
    import serial_bus_pkg::*;
#(
    parameter int ADDR_LEN  = ADDR_LEN_DEF,
    parameter int DATA_LEN  = DATA_LEN_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic read_en,
    input  logic write_en,
    input  logic master_valid,
    output logic slave_ready,
    input  logic rx_addr,
    input  logic rx_burst,
    input  logic rx_data,
    output logic tx_data,
    output logic slave_valid,
    input  logic master_ready,
    output logic slave_done
);

    localparam int HDR_LEN = hdr_len(ADDR_LEN, BURST_LEN);
    localparam int HCNT_W  = $clog2(HDR_LEN);
    localparam int DCNT_W  = $clog2(DATA_LEN);

    bus_state_e           state_q, state_d;
    logic [ADDR_LEN-1:0]  addr_q, addr_d;
    logic [BURST_LEN-1:0] remaining_q, remaining_d;
    logic [HCNT_W-1:0]    hdr_cnt_q, hdr_cnt_d;
    logic [DCNT_W-1:0]    data_cnt_q, data_cnt_d;
    logic [DATA_LEN-1:0]  beat_q, beat_d;
    logic                 mode_wr_q, mode_wr_d;
    logic                 slave_ready_q, slave_ready_d;
    logic                 slave_valid_q, slave_valid_d;
    logic                 tx_data_q, tx_data_d;
    logic                 slave_done_q, slave_done_d;

    logic                 mem_we;
    logic [ADDR_LEN-1:0]  mem_addr;
    logic [DATA_LEN-1:0]  mem_rdata;
    logic                 rx_take, tx_take, enables_ok;
    logic [DCNT_W-1:0]    data_cnt_inc;

    assign rx_take      = master_valid && slave_ready_q;
    assign tx_take      = slave_valid_q && master_ready;
    // Anything other than the single enable the transaction started with
    // (both low, both high, or switched) aborts.
    assign enables_ok   = mode_wr_q ? (write_en && !read_en) : (read_en && !write_en);
    assign data_cnt_inc = data_cnt_q + DCNT_W'(1);
    // Reads are addressed with the next address so the data is already
    // present during RD_FETCH; writes use the committed beat's address.
    assign mem_addr     = (state_q == WR_COMMIT) ? addr_q : addr_d;

    slave_bram #(
        .ADDR_W (ADDR_LEN),
        .DATA_W (DATA_LEN)
    ) u_bram (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (beat_q),
        .rdata (mem_rdata)
    );

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        hdr_cnt_d    = hdr_cnt_q;
        data_cnt_d   = data_cnt_q;
        beat_d       = beat_q;
        mode_wr_d    = mode_wr_q;
        tx_data_d    = 1'b0;
        slave_done_d = 1'b0;
        mem_we       = 1'b0;

        if (state_q != IDLE && !enables_ok) begin
            state_d    = IDLE;
            hdr_cnt_d  = '0;
            data_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_take && (read_en ^ write_en)) begin
                        mode_wr_d      = write_en;
                        addr_d         = '0;
                        remaining_d    = '0;
                        addr_d[0]      = rx_addr;
                        remaining_d[0] = rx_burst;
                        hdr_cnt_d      = HCNT_W'(1);
                        state_d        = HEADER;
                    end
                end
                HEADER: begin
                    if (rx_take) begin
                        if (32'(hdr_cnt_q) < ADDR_LEN) begin
                            addr_d[hdr_cnt_q] = rx_addr;
                        end
                        if (32'(hdr_cnt_q) < BURST_LEN) begin
                            remaining_d[hdr_cnt_q] = rx_burst;
                        end
                        if (hdr_cnt_q == HCNT_W'(HDR_LEN - 1)) begin
                            hdr_cnt_d = '0;
                            if (remaining_d == '0) begin
                                remaining_d = BURST_LEN'(1);
                            end
                            state_d = mode_wr_q ? WR_DATA : RD_FETCH;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + HCNT_W'(1);
                        end
                    end
                end
                WR_DATA: begin
                    if (rx_take) begin
                        beat_d[data_cnt_q] = rx_data;
                        if (data_cnt_q == DCNT_W'(DATA_LEN - 1)) begin
                            data_cnt_d = '0;
                            state_d    = WR_COMMIT;
                        end else begin
                            data_cnt_d = data_cnt_inc;
                        end
                    end
                end
                WR_COMMIT: begin
                    mem_we      = 1'b1;
                    addr_d      = addr_q + ADDR_LEN'(1);
                    remaining_d = remaining_q - BURST_LEN'(1);
                    if (remaining_q == BURST_LEN'(1)) begin
                        slave_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        state_d = WR_DATA;
                    end
                end
                RD_FETCH: begin
                    beat_d     = mem_rdata;
                    tx_data_d  = mem_rdata[0];
                    data_cnt_d = '0;
                    state_d    = RD_SEND;
                end
                RD_SEND: begin
                    tx_data_d = tx_data_q;
                    if (tx_take) begin
                        if (data_cnt_q == DCNT_W'(DATA_LEN - 1)) begin
                            data_cnt_d  = '0;
                            tx_data_d   = 1'b0;
                            addr_d      = addr_q + ADDR_LEN'(1);
                            remaining_d = remaining_q - BURST_LEN'(1);
                            if (remaining_q == BURST_LEN'(1)) begin
                                slave_done_d = 1'b1;
                                state_d      = IDLE;
                            end else begin
                                state_d = RD_FETCH;
                            end
                        end else begin
                            data_cnt_d = data_cnt_inc;
                            tx_data_d  = beat_q[data_cnt_inc];
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        slave_ready_d = (state_d == IDLE) || (state_d == HEADER) || (state_d == WR_DATA);
        slave_valid_d = (state_d == RD_SEND);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            hdr_cnt_q     <= '0;
            data_cnt_q    <= '0;
            beat_q        <= '0;
            mode_wr_q     <= 1'b0;
            slave_ready_q <= 1'b0;
            slave_valid_q <= 1'b0;
            tx_data_q     <= 1'b0;
            slave_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            hdr_cnt_q     <= hdr_cnt_d;
            data_cnt_q    <= data_cnt_d;
            beat_q        <= beat_d;
            mode_wr_q     <= mode_wr_d;
            slave_ready_q <= slave_ready_d;
            slave_valid_q <= slave_valid_d;
            tx_data_q     <= tx_data_d;
            slave_done_q  <= slave_done_d;
        end
    end

    assign slave_ready = slave_ready_q;
    assign slave_valid = slave_valid_q;
    assign tx_data     = tx_data_q;
    assign slave_done  = slave_done_q;

endmodule
